// File: rtl/panel_pkg.sv
// Shared constants and FSM state encoding for the UDP pixel unpacker and the
// ledpanel control bus.
package panel_pkg;

  localparam int PANEL_COUNT = 6;
  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 24;

  localparam logic [7:0] ID_LED       = 8'h00;
  localparam logic [7:0] ID_BROADCAST = 8'hFF;

  typedef enum logic [2:0] {
    HDR_ID  = 3'd0,
    ADDR_HI = 3'd1,
    ADDR_LO = 3'd2,
    PIX_R   = 3'd3,
    PIX_G   = 3'd4,
    PIX_B   = 3'd5,
    LED_ARG = 3'd6,
    DRAIN   = 3'd7
  } state_t;

endpackage

// File: rtl/udp_pixel_unpacker.sv
// Parses UDP payloads (ID, big-endian start address, RGB triples) into one
// single-cycle write per pixel on the shared ledpanel control bus.
module udp_pixel_unpacker
  import panel_pkg::*;
#(
  parameter int PANEL_COUNT = panel_pkg::PANEL_COUNT,
  parameter int EN_WIDTH    = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                udp0_source_valid,
  input  logic                udp0_source_last,
  output logic                udp0_source_ready,
  input  logic [7:0]          udp0_source_data,
  input  logic                udp0_source_error,
  output logic [EN_WIDTH-1:0] ctrl_en,
  output logic [3:0]          ctrl_wr,
  output logic [ADDR_W-1:0]   ctrl_addr,
  output logic [DATA_W-1:0]   ctrl_wdat,
  output logic                led_reg,
  output logic [2:0]          fsm_state
);

  // Handshake: a byte transfers on every rising clock where valid and ready
  // are both high; ready is never withdrawn once out of reset.

  state_t                state;
  logic [EN_WIDTH-1:0]   en_mask;
  logic [ADDR_W-1:0]     addr;
  logic [7:0]            r_byte;
  logic [7:0]            g_byte;
  logic                  accept;
  logic                  abort;
  logic                  id_is_panel;

  assign accept      = udp0_source_valid & udp0_source_ready;
  assign abort       = udp0_source_last & udp0_source_error;
  assign id_is_panel = (udp0_source_data != ID_LED) &&
                       (udp0_source_data <= 8'(PANEL_COUNT));
  assign fsm_state   = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= HDR_ID;
      udp0_source_ready <= 1'b0;
      en_mask           <= '0;
      addr              <= '0;
      r_byte            <= '0;
      g_byte            <= '0;
      ctrl_en           <= '0;
      ctrl_wr           <= '0;
      ctrl_addr         <= '0;
      ctrl_wdat         <= '0;
      led_reg           <= 1'b0;
    end else begin
      udp0_source_ready <= 1'b1;
      ctrl_en           <= '0;
      ctrl_wr           <= '0;
      if (accept) begin
        case (state)
          HDR_ID: begin
            if (id_is_panel) begin
              en_mask <= EN_WIDTH'(1) << (udp0_source_data - 8'd1);
              state   <= ADDR_HI;
            end else if (udp0_source_data == ID_BROADCAST) begin
              en_mask <= '1;
              state   <= ADDR_HI;
            end else if (udp0_source_data == ID_LED) begin
              state <= LED_ARG;
            end else begin
              state <= DRAIN;
            end
          end
          ADDR_HI: begin
            addr[15:8] <= udp0_source_data;
            state      <= ADDR_LO;
          end
          ADDR_LO: begin
            addr[7:0] <= udp0_source_data;
            state     <= PIX_R;
          end
          PIX_R: begin
            r_byte <= udp0_source_data;
            state  <= PIX_G;
          end
          PIX_G: begin
            g_byte <= udp0_source_data;
            state  <= PIX_B;
          end
          PIX_B: begin
            // An errored packet loses the pixel its final byte would complete.
            if (!abort) begin
              ctrl_en   <= en_mask;
              ctrl_wr   <= 4'b0111;
              ctrl_addr <= addr;
              ctrl_wdat <= {r_byte, g_byte, udp0_source_data};
            end
            addr  <= addr + 16'd1;
            state <= PIX_R;
          end
          LED_ARG: begin
            if (!abort) led_reg <= udp0_source_data[0];
            state <= DRAIN;
          end
          default: state <= DRAIN;
        endcase
        if (udp0_source_last) state <= HDR_ID;
      end
    end
  end

endmodule

// File: tb/tb_udp_pixel_unpacker.sv
// Directed and randomized bench for udp_pixel_unpacker; expected writes come
// from a packet-level reference model feeding a scoreboard queue.
module tb_udp_pixel_unpacker;

  logic        clock = 1'b0;
  logic        reset;
  logic        udp0_source_valid;
  logic        udp0_source_last;
  logic        udp0_source_ready;
  logic [7:0]  udp0_source_data;
  logic        udp0_source_error;
  logic [7:0]  ctrl_en;
  logic [3:0]  ctrl_wr;
  logic [15:0] ctrl_addr;
  logic [23:0] ctrl_wdat;
  logic        led_reg;
  logic [2:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [47:0] exp_q[$];
  logic [7:0]  pkt_q[$];
  int          wr_cyc[$];
  logic        exp_led = 1'b0;
  bit          gap_en  = 1'b0;

  udp_pixel_unpacker #(.PANEL_COUNT(6), .EN_WIDTH(8)) dut (
    .clock             (clock),
    .reset             (reset),
    .udp0_source_valid (udp0_source_valid),
    .udp0_source_last  (udp0_source_last),
    .udp0_source_ready (udp0_source_ready),
    .udp0_source_data  (udp0_source_data),
    .udp0_source_error (udp0_source_error),
    .ctrl_en           (ctrl_en),
    .ctrl_wr           (ctrl_wr),
    .ctrl_addr         (ctrl_addr),
    .ctrl_wdat         (ctrl_wdat),
    .led_reg           (led_reg),
    .fsm_state         (fsm_state)
  );

  // Clock and cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cycle++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every non-zero ctrl_en cycle must match the next expected write
  always @(negedge clock) begin
    if (reset === 1'b0 && ctrl_en !== 8'h00) begin
      check("ctrl_wr", 64'(ctrl_wr), 64'h7);
      if (exp_q.size() == 0)
        check("unexpected_write", 64'({ctrl_en, ctrl_addr, ctrl_wdat}), 64'h0);
      else
        check("write", 64'({ctrl_en, ctrl_addr, ctrl_wdat}), 64'(exp_q.pop_front()));
      wr_cyc.push_back(cycle);
    end
  end

  // Packet-level reference: which pixels a payload yields and what it does to the LED
  task automatic ref_model(input bit err);
    int          n;
    int          npix;
    logic [7:0]  id;
    logic [7:0]  en;
    logic [15:0] a;
    n = pkt_q.size();
    if (n == 0) return;
    id = pkt_q[0];
    if ((id >= 8'd1 && id <= 8'd6) || id == 8'hFF) begin
      en = (id == 8'hFF) ? 8'hFF : 8'(1 << (id - 8'd1));
      if (n >= 3) begin
        a    = {pkt_q[1], pkt_q[2]};
        npix = (n - 3) / 3;
        if (err && npix > 0 && ((n - 3) % 3) == 0) npix--;
        for (int i = 0; i < npix; i++)
          exp_q.push_back({en, a + 16'(i), pkt_q[3+3*i], pkt_q[4+3*i], pkt_q[5+3*i]});
      end
    end else if (id == 8'h00 && n >= 2 && !(err && n == 2)) begin
      exp_led = pkt_q[1][0];
    end
  endtask

  // Driver: one byte per negedge, optional idle gaps, error only with last
  task automatic send_pkt(input bit err);
    int n;
    n = pkt_q.size();
    ref_model(err);
    for (int i = 0; i < n; i++) begin
      if (gap_en && $urandom_range(0, 2) == 0) begin
        @(negedge clock);
        udp0_source_valid = 1'b0;
        udp0_source_last  = 1'b0;
        udp0_source_error = 1'b0;
      end
      @(negedge clock);
      udp0_source_valid = 1'b1;
      udp0_source_data  = pkt_q[i];
      udp0_source_last  = (i == n - 1);
      udp0_source_error = err && (i == n - 1);
    end
    @(negedge clock);
    udp0_source_valid = 1'b0;
    udp0_source_last  = 1'b0;
    udp0_source_error = 1'b0;
  endtask

  task automatic settle(input string tag);
    repeat (4) @(negedge clock);
    check({tag, "_pending"}, 64'(exp_q.size()), 64'h0);
    check({tag, "_led"}, 64'(led_reg), 64'(exp_led));
  endtask

  task automatic add_pixels(input int cnt);
    for (int i = 0; i < cnt * 3; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    logic [7:0] r;
    int         len;
    reset             = 1'b1;
    udp0_source_valid = 1'b0;
    udp0_source_last  = 1'b0;
    udp0_source_data  = 8'h00;
    udp0_source_error = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_ready", 64'(udp0_source_ready), 64'h0);
    check("rst_outputs", 64'({ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat, led_reg}), 64'h0);
    check("rst_state", 64'(fsm_state), 64'h0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", 64'(udp0_source_ready), 64'h1);

    // Panel 3, two pixels, writes three cycles apart
    pkt_q = '{8'h03, 8'h01, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    wr_cyc.delete();
    send_pkt(1'b0);
    settle("panel3");
    check("panel3_count", 64'(wr_cyc.size()), 64'h2);
    if (wr_cyc.size() == 2) check("panel3_spacing", 64'(wr_cyc[1] - wr_cyc[0]), 64'h3);

    // Broadcast with address wrap
    pkt_q = '{8'hFF, 8'hFF, 8'hFF};
    add_pixels(2);
    send_pkt(1'b0);
    settle("bcast_wrap");

    // Panel 1, three pixels plus two stray bytes, then a clean packet
    pkt_q = '{8'h01, 8'h20, 8'h00};
    add_pixels(3);
    pkt_q.push_back(8'hDE);
    pkt_q.push_back(8'hAD);
    send_pkt(1'b0);
    settle("trailing");
    pkt_q = '{8'h06, 8'h00, 8'h05, 8'h0A, 8'h0B, 8'h0C};
    send_pkt(1'b0);
    settle("after_trailing");

    // Short packets ending in the address bytes
    pkt_q = '{8'h04, 8'h12};
    send_pkt(1'b0);
    settle("end_addr_hi");

    // Bad ID and LED commands
    pkt_q = '{8'h07, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
    send_pkt(1'b0);
    settle("bad_id");
    pkt_q = '{8'h00, 8'h01};
    send_pkt(1'b0);
    check("led_set", 64'(led_reg), 64'h1);
    settle("led_cmd");
    pkt_q = '{8'h00};
    send_pkt(1'b0);
    settle("led_short");
    pkt_q = '{8'h00};
    send_pkt(1'b0);
    settle("led_short2");

    // Error on final B byte, then error on a third pixel's R byte
    pkt_q = '{8'h02, 8'h00, 8'h40};
    add_pixels(2);
    send_pkt(1'b1);
    settle("err_on_b");
    pkt_q = '{8'h02, 8'h00, 8'h40};
    add_pixels(2);
    pkt_q.push_back(8'h99);
    send_pkt(1'b1);
    settle("err_on_r");

    // Asynchronous reset while a pixel is half assembled
    pkt_q = '{8'h02, 8'h00, 8'h00, 8'h11, 8'h22};
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      udp0_source_valid = 1'b1;
      udp0_source_data  = pkt_q[i];
    end
    @(negedge clock);
    udp0_source_data = pkt_q[4];
    #2 reset = 1'b1;
    #1;
    check("async_rst_ready", 64'(udp0_source_ready), 64'h0);
    check("async_rst_outputs", 64'({ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat, led_reg}), 64'h0);
    check("async_rst_state", 64'(fsm_state), 64'h0);
    exp_led = 1'b0;
    udp0_source_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_rerelease", 64'(udp0_source_ready), 64'h1);
    pkt_q = '{8'h05, 8'h00, 8'h10, 8'hAA, 8'hBB, 8'hCC};
    send_pkt(1'b0);
    settle("post_reset");

    // Randomized packets with idle gaps
    gap_en = 1'b1;
    for (int p = 0; p < 40; p++) begin
      r = 8'($urandom_range(0, 9));
      case (r)
        8'd6:    r = 8'hFF;
        8'd7:    r = 8'h00;
        8'd8:    r = 8'h07;
        8'd9:    r = 8'($urandom_range(0, 255));
        default: r = r + 8'd1;
      endcase
      len   = $urandom_range(1, 16);
      pkt_q = '{r};
      for (int i = 1; i < len; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
      send_pkt($urandom_range(0, 3) == 0);
      settle("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
